// File: rtl/cpu_ctrl_fsm_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
//   Shared definitions for the 8-bit CPU hardwired control unit: state
//   encodings, opcode values, bus-select and ALU-op codes, and the packed
//   strobe vector that the control unit hands to the datapath.
//   Imported by the control FSM, its output decoder, the control interface
//   and any datapath or bench that talks to them.
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

  // Control states; encoding 4'd15 is unused and recovers to S_F1.
  typedef enum logic [3:0] {
    S_F1   = 4'd0,
    S_F2   = 4'd1,
    S_F3   = 4'd2,
    S_DEC  = 4'd3,
    S_A1   = 4'd4,
    S_A2   = 4'd5,
    S_A3   = 4'd6,
    S_LD1  = 4'd7,
    S_LD2  = 4'd8,
    S_ST1  = 4'd9,
    S_ST2  = 4'd10,
    S_JZ   = 4'd11,
    S_SK   = 4'd12,
    S_EX   = 4'd13,
    S_HALT = 4'd14
  } state_t;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOP  = 4'h0;
  localparam opcode_t OP_LDAC = 4'h1;
  localparam opcode_t OP_STAC = 4'h2;
  localparam opcode_t OP_MVAC = 4'h3;
  localparam opcode_t OP_MOVR = 4'h4;
  localparam opcode_t OP_JUMP = 4'h5;
  localparam opcode_t OP_JMPZ = 4'h6;
  localparam opcode_t OP_JPNZ = 4'h7;
  localparam opcode_t OP_ADD  = 4'h8;
  localparam opcode_t OP_SUB  = 4'h9;
  localparam opcode_t OP_INAC = 4'hA;
  localparam opcode_t OP_CLAC = 4'hB;
  localparam opcode_t OP_AND  = 4'hC;
  localparam opcode_t OP_OR   = 4'hD;
  localparam opcode_t OP_XOR  = 4'hE;
  localparam opcode_t OP_HALT = 4'hF;

  // Bus source select; a single code means at most one driver on the bus.
  typedef logic [2:0] bus_sel_t;

  localparam bus_sel_t BUS_NONE = 3'd0;
  localparam bus_sel_t BUS_PC   = 3'd1;
  localparam bus_sel_t BUS_DR   = 3'd2;
  localparam bus_sel_t BUS_AC   = 3'd3;
  localparam bus_sel_t BUS_R    = 3'd4;
  localparam bus_sel_t BUS_MEM  = 3'd5;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_PASS = 4'd0;
  localparam alu_op_t ALU_ADD  = 4'd1;
  localparam alu_op_t ALU_SUB  = 4'd2;
  localparam alu_op_t ALU_INC  = 4'd3;
  localparam alu_op_t ALU_CLR  = 4'd4;
  localparam alu_op_t ALU_AND  = 4'd5;
  localparam alu_op_t ALU_OR   = 4'd6;
  localparam alu_op_t ALU_XOR  = 4'd7;

  // Complete set of datapath strobes driven by the control unit.
  typedef struct packed {
    logic     arload;
    logic     pcload;
    logic     pcinc;
    logic     drload;
    logic     irload;
    logic     acload;
    logic     rload;
    logic     zload;
    logic     rd;
    logic     wr;
    bus_sel_t bus_sel;
    alu_op_t  alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // AR <= PC: first step of both the opcode fetch and the operand fetch.
  function automatic ctrl_t ctrl_ar_from_pc();
    ctrl_t c;
    c         = CTRL_IDLE;
    c.arload  = 1'b1;
    c.bus_sel = BUS_PC;
    return c;
  endfunction

  // DR <= MEM[AR] with PC advanced past the byte just read.
  function automatic ctrl_t ctrl_mem_to_dr_inc();
    ctrl_t c;
    c         = CTRL_IDLE;
    c.rd      = 1'b1;
    c.drload  = 1'b1;
    c.pcinc   = 1'b1;
    c.bus_sel = BUS_MEM;
    return c;
  endfunction

  // ALU function for the two-operand / accumulator-only instructions.
  function automatic alu_op_t alu_for_op(opcode_t op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_INAC: return ALU_INC;
      OP_CLAC: return ALU_CLR;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_fsm_if
//   Bundle between the control unit and the datapath.
//   Datapath -> control : run, ir_q[7:0], zflag
//   Control -> datapath : arload, pcload, pcinc, drload, irload, acload,
//                         rload, zload, rd, wr, bus_sel[2:0], alu_op[3:0],
//                         halted
//   master : control unit side
//   slave  : datapath side
// ---------------------------------------------------------------------------
interface cpu_ctrl_fsm_if;
  import cpu_ctrl_pkg::*;

  logic       run;
  logic [7:0] ir_q;
  logic       zflag;

  logic       arload;
  logic       pcload;
  logic       pcinc;
  logic       drload;
  logic       irload;
  logic       acload;
  logic       rload;
  logic       zload;
  logic       rd;
  logic       wr;
  bus_sel_t   bus_sel;
  alu_op_t    alu_op;
  logic       halted;

  modport master (
    input  run, ir_q, zflag,
    output arload, pcload, pcinc, drload, irload, acload, rload, zload,
           rd, wr, bus_sel, alu_op, halted
  );

  modport slave (
    output run, ir_q, zflag,
    input  arload, pcload, pcinc, drload, irload, acload, rload, zload,
           rd, wr, bus_sel, alu_op, halted
  );

endinterface

// File: rtl/cpu_ctrl_fsm_out.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_out
//   Pure combinational strobe decode for one control state.
//   state  in  4  control state to decode
//   opcode in  4  latched opcode (ir_q[7:4])
//   ctrl   out    full strobe vector for that state
//   halted out 1  state is S_HALT
// ---------------------------------------------------------------------------
module cpu_ctrl_out
  import cpu_ctrl_pkg::*;
(
  input  state_t  state,
  input  opcode_t opcode,
  output ctrl_t   ctrl,
  output logic    halted
);

  always_comb begin
    ctrl   = CTRL_IDLE;
    halted = 1'b0;
    case (state)
      S_F1, S_A1: ctrl = ctrl_ar_from_pc();
      S_F2, S_A2: ctrl = ctrl_mem_to_dr_inc();
      S_F3:       ctrl.irload = 1'b1;
      S_A3: begin
        // Operand byte in DR is either a memory address or a jump target;
        // the taken conditional jumps share the JUMP path.
        ctrl.bus_sel = BUS_DR;
        if (opcode == OP_LDAC || opcode == OP_STAC) begin
          ctrl.arload = 1'b1;
        end else begin
          ctrl.pcload = 1'b1;
        end
      end
      S_LD1: begin
        ctrl.rd      = 1'b1;
        ctrl.drload  = 1'b1;
        ctrl.bus_sel = BUS_MEM;
      end
      S_LD2: begin
        ctrl.bus_sel = BUS_DR;
        ctrl.alu_op  = ALU_PASS;
        ctrl.acload  = 1'b1;
        ctrl.zload   = 1'b1;
      end
      S_ST1: begin
        ctrl.bus_sel = BUS_AC;
        ctrl.drload  = 1'b1;
      end
      S_ST2: begin
        ctrl.bus_sel = BUS_DR;
        ctrl.wr      = 1'b1;
      end
      S_SK: ctrl.pcinc = 1'b1;
      S_EX: begin
        case (opcode)
          OP_MVAC: begin
            ctrl.bus_sel = BUS_AC;
            ctrl.rload   = 1'b1;
          end
          OP_MOVR: begin
            ctrl.bus_sel = BUS_R;
            ctrl.alu_op  = ALU_PASS;
            ctrl.acload  = 1'b1;
            ctrl.zload   = 1'b1;
          end
          default: begin
            // R feeds the ALU directly, so the shared bus stays idle.
            ctrl.alu_op = alu_for_op(opcode);
            ctrl.acload = 1'b1;
            ctrl.zload  = 1'b1;
          end
        endcase
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_fsm
//   Hardwired fetch/decode/execute sequencer of the 8-bit CPU.
//   Parameters:
//     OPW           opcode width, opcode = ir_q[7 -: OPW]
//     HALT_ON_RESET 1 leaves reset in S_HALT, 0 in S_F1
//   Ports:
//     clk  in  1  state and strobe registers update on the rising edge
//     rst  in  1  asynchronous, active-low reset
//     cif  master side of cpu_ctrl_fsm_if (run, ir_q, zflag in; all
//          datapath strobes, bus_sel, alu_op, halted out)
// ---------------------------------------------------------------------------
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW           = 4,
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  cpu_ctrl_fsm_if.master   cif
);

  localparam state_t RESET_STATE = HALT_ON_RESET ? S_HALT : S_F1;

  // Strobe registers reset to the decode of the reset state, so the first
  // S_F1 after release already loads AR; the gate below keeps them quiet
  // while rst is held.
  localparam ctrl_t  RESET_CTRL  = HALT_ON_RESET ? CTRL_IDLE : ctrl_ar_from_pc();

  state_t  state;
  state_t  next_state;
  opcode_t opcode;
  logic    jz_taken;
  ctrl_t   ctrl_next;
  logic    halted_next;
  ctrl_t   ctrl_q;
  logic    halted_q;
  ctrl_t   ctrl_out;
  logic    ir_low_unused;

  assign opcode        = opcode_t'(cif.ir_q[7 -: OPW]);
  assign ir_low_unused = ^cif.ir_q[7-OPW:0];

  // Only ever evaluated for JMPZ/JPNZ, i.e. while sitting in S_JZ.
  assign jz_taken = (opcode == OP_JMPZ) ? cif.zflag : ~cif.zflag;

  always_comb begin
    next_state = S_F1;
    case (state)
      S_F1: next_state = S_F2;
      S_F2: next_state = S_F3;
      S_F3: next_state = S_DEC;
      S_DEC: begin
        case (opcode)
          OP_NOP:                    next_state = S_F1;
          OP_LDAC, OP_STAC, OP_JUMP: next_state = S_A1;
          OP_JMPZ, OP_JPNZ:          next_state = S_JZ;
          OP_HALT:                   next_state = S_HALT;
          default:                   next_state = S_EX;
        endcase
      end
      S_A1: next_state = S_A2;
      S_A2: next_state = S_A3;
      S_A3: begin
        if (opcode == OP_LDAC) begin
          next_state = S_LD1;
        end else if (opcode == OP_STAC) begin
          next_state = S_ST1;
        end else begin
          next_state = S_F1;
        end
      end
      S_LD1:  next_state = S_LD2;
      S_LD2:  next_state = S_F1;
      S_ST1:  next_state = S_ST2;
      S_ST2:  next_state = S_F1;
      S_JZ:   next_state = jz_taken ? S_A1 : S_SK;
      S_SK:   next_state = S_F1;
      S_EX:   next_state = S_F1;
      S_HALT: next_state = cif.run ? S_F1 : S_HALT;
      default: next_state = S_F1;
    endcase
  end

  // Decoding the next state lets the strobes be registered alongside the
  // state, so they are glitch-free for the datapath's falling-edge loads.
  cpu_ctrl_out u_out (
    .state  (next_state),
    .opcode (opcode),
    .ctrl   (ctrl_next),
    .halted (halted_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RESET_STATE;
      ctrl_q   <= RESET_CTRL;
      halted_q <= HALT_ON_RESET;
    end else begin
      state    <= next_state;
      ctrl_q   <= ctrl_next;
      halted_q <= halted_next;
    end
  end

  // Asserting rst kills every strobe immediately, including an in-flight wr.
  assign ctrl_out = rst ? ctrl_q : CTRL_IDLE;

  assign cif.arload  = ctrl_out.arload;
  assign cif.pcload  = ctrl_out.pcload;
  assign cif.pcinc   = ctrl_out.pcinc;
  assign cif.drload  = ctrl_out.drload;
  assign cif.irload  = ctrl_out.irload;
  assign cif.acload  = ctrl_out.acload;
  assign cif.rload   = ctrl_out.rload;
  assign cif.zload   = ctrl_out.zload;
  assign cif.rd      = ctrl_out.rd;
  assign cif.wr      = ctrl_out.wr;
  assign cif.bus_sel = ctrl_out.bus_sel;
  assign cif.alu_op  = ctrl_out.alu_op;
  assign cif.halted  = halted_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_cpu_ctrl_fsm
//   Self-checking bench for cpu_ctrl_fsm. Each instruction is expanded into
//   its expected per-cycle strobe pattern from the instruction's micro-op
//   description; a compare process checks the DUT against that queue on
//   every falling edge. A small IR register model loads ir_q on irload.
// ---------------------------------------------------------------------------
module tb_cpu_ctrl_fsm;

  // Strobe bits, MSB first: arload pcload pcinc drload irload acload rload
  // zload rd wr. Expected vector = {strobes[9:0], bus[2:0], alu[3:0], halted}.
  localparam logic [9:0] AR  = 10'b10_0000_0000;
  localparam logic [9:0] PCL = 10'b01_0000_0000;
  localparam logic [9:0] PCI = 10'b00_1000_0000;
  localparam logic [9:0] DRL = 10'b00_0100_0000;
  localparam logic [9:0] IRL = 10'b00_0010_0000;
  localparam logic [9:0] ACL = 10'b00_0001_0000;
  localparam logic [9:0] RL  = 10'b00_0000_1000;
  localparam logic [9:0] ZL  = 10'b00_0000_0100;
  localparam logic [9:0] RD  = 10'b00_0000_0010;
  localparam logic [9:0] WR  = 10'b00_0000_0001;

  localparam int B_PCLOAD = 16;
  localparam int B_PCINC  = 15;
  localparam int B_WR     = 8;

  logic        clk;
  logic        rst;
  logic [7:0]  ir_reg;
  logic [7:0]  next_instr;
  logic [3:0]  cur_op;
  logic        chk_en;
  logic [17:0] exp_q[$];
  logic [17:0] mdl_q[$];
  int          n_checks;
  int          n_fail;

  logic [3:0] dir_op [18] = '{4'h0, 4'h8, 4'h2, 4'h6, 4'h6, 4'h7, 4'h7, 4'h1, 4'h5,
                              4'h3, 4'h4, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
  logic       dir_z  [18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                              1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  cpu_ctrl_fsm_if cif ();

  cpu_ctrl_fsm dut (
    .clk (clk),
    .rst (rst),
    .cif (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction register: loads the byte fetched into DR on the falling edge.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      ir_reg <= 8'h00;
    end else if (cif.irload === 1'b1) begin
      ir_reg <= next_instr;
    end
  end

  assign cif.ir_q = ir_reg;

  function automatic logic [17:0] mk(logic [9:0] st, int bus, int alu, logic h);
    return {st, 3'(bus), 4'(alu), h};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {cif.arload, cif.pcload, cif.pcinc, cif.drload, cif.irload,
            cif.acload, cif.rload, cif.zload, cif.rd, cif.wr,
            cif.bus_sel, cif.alu_op, cif.halted};
  endfunction

  // Operand byte fetch followed by the instruction-specific tail.
  function automatic void addrTail(logic [3:0] kind);
    mdl_q.push_back(mk(AR, 1, 0, 1'b0));
    mdl_q.push_back(mk(RD | DRL | PCI, 5, 0, 1'b0));
    case (kind)
      4'h1: begin
        mdl_q.push_back(mk(AR, 2, 0, 1'b0));
        mdl_q.push_back(mk(RD | DRL, 5, 0, 1'b0));
        mdl_q.push_back(mk(ACL | ZL, 2, 0, 1'b0));
      end
      4'h2: begin
        mdl_q.push_back(mk(AR, 2, 0, 1'b0));
        mdl_q.push_back(mk(DRL, 3, 0, 1'b0));
        mdl_q.push_back(mk(WR, 2, 0, 1'b0));
      end
      default: mdl_q.push_back(mk(PCL, 2, 0, 1'b0));
    endcase
  endfunction

  // Expected cycle-by-cycle outputs of one whole instruction.
  function automatic void buildExpected(logic [3:0] op, logic z, int halt_n);
    logic taken;
    mdl_q.delete();
    mdl_q.push_back(mk(AR, 1, 0, 1'b0));
    mdl_q.push_back(mk(RD | DRL | PCI, 5, 0, 1'b0));
    mdl_q.push_back(mk(IRL, 0, 0, 1'b0));
    mdl_q.push_back(mk(10'b0, 0, 0, 1'b0));
    if (op == 4'h1 || op == 4'h2 || op == 4'h5) begin
      addrTail(op);
    end else if (op == 4'h6 || op == 4'h7) begin
      taken = (op == 4'h6) ? z : ~z;
      mdl_q.push_back(mk(10'b0, 0, 0, 1'b0));
      if (taken) addrTail(4'h5);
      else       mdl_q.push_back(mk(PCI, 0, 0, 1'b0));
    end else if (op == 4'h3) begin
      mdl_q.push_back(mk(RL, 3, 0, 1'b0));
    end else if (op == 4'h4) begin
      mdl_q.push_back(mk(ACL | ZL, 4, 0, 1'b0));
    end else if (op >= 4'h8 && op <= 4'hE) begin
      mdl_q.push_back(mk(ACL | ZL, 0, int'(op) - 7, 1'b0));
    end else if (op == 4'hF) begin
      for (int i = 0; i < halt_n; i++) mdl_q.push_back(mk(10'b0, 0, 0, 1'b1));
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Runs one instruction starting at 2 time units after the rising edge
  // that entered S_F1; returns at the same point of the next S_F1.
  task automatic applyStimulus(input logic [3:0] op, input logic z, input int halt_n);
    int len;
    buildExpected(op, z, halt_n);
    len = mdl_q.size();
    foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
    cur_op     = op;
    next_instr = {op, 4'($urandom)};
    for (int i = 0; i < len; i++) begin
      if (op == 4'hF && i >= 4) cif.run = (i == len - 1);
      else                      cif.run = 1'($urandom);
      cif.zflag = (i == 4) ? z : 1'($urandom);
      @(posedge clk);
      #2;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL model_underflow: got outputs %h, required none queued", dut_vec());
      end else begin
        checkOutput($sformatf("op%h_left%0d", cur_op, exp_q.size() - 1),
                    32'(dut_vec()), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [17:0] e;
    int          cnt;
    n_checks   = 0;
    n_fail     = 0;
    chk_en     = 1'b0;
    rst        = 1'b0;
    cif.run    = 1'b0;
    cif.zflag  = 1'b0;
    next_instr = 8'h00;
    cur_op     = 4'h0;

    // Hand-computed pins on the reference model.
    buildExpected(4'h0, 1'b0, 0); checkOutput("len_nop",   32'(mdl_q.size()), 32'd4);
    buildExpected(4'h8, 1'b0, 0); checkOutput("len_add",   32'(mdl_q.size()), 32'd5);
    e = mdl_q[4];                 checkOutput("add_ex",    32'(e), 32'h0_1402);
    buildExpected(4'h3, 1'b0, 0); checkOutput("len_mvac",  32'(mdl_q.size()), 32'd5);
    buildExpected(4'h5, 1'b0, 0); checkOutput("len_jump",  32'(mdl_q.size()), 32'd7);
    buildExpected(4'h1, 1'b0, 0); checkOutput("len_ldac",  32'(mdl_q.size()), 32'd9);
    buildExpected(4'h2, 1'b0, 0); checkOutput("len_stac",  32'(mdl_q.size()), 32'd9);
    e = mdl_q[8];
    checkOutput("stac_c9_wr_bus", {28'd0, e[B_WR], e[7:5]}, {28'd0, 1'b1, 3'd2});
    cnt = 0;
    foreach (mdl_q[i]) begin e = mdl_q[i]; cnt += int'(e[B_WR]); end
    checkOutput("stac_wr_count", 32'(cnt), 32'd1);
    cnt = 0;
    foreach (mdl_q[i]) begin e = mdl_q[i]; cnt += int'(e[B_PCINC]); end
    checkOutput("stac_pcinc_count", 32'(cnt), 32'd2);
    buildExpected(4'h6, 1'b1, 0); checkOutput("len_jmpz_taken", 32'(mdl_q.size()), 32'd8);
    e = mdl_q[7];                 checkOutput("jmpz_c8_pcload", 32'(e[B_PCLOAD]), 32'd1);
    buildExpected(4'h6, 1'b0, 0); checkOutput("len_jmpz_skip",  32'(mdl_q.size()), 32'd6);
    cnt = 0;
    foreach (mdl_q[i]) begin e = mdl_q[i]; cnt += int'(e[B_PCLOAD]); end
    checkOutput("jmpz_skip_no_pcload", 32'(cnt), 32'd0);
    buildExpected(4'h7, 1'b0, 0); checkOutput("len_jpnz_taken", 32'(mdl_q.size()), 32'd8);

    // Reset state while rst is held.
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_outputs", 32'(dut_vec()), 32'd0);
    rst = 1'b1;

    $display("[TB] directed instructions");
    chk_en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(dir_op[i], dir_z[i], (dir_op[i] == 4'hF) ? 20 : 0);
    end

    $display("[TB] reset in the middle of a fetch");
    chk_en     = 1'b0;
    next_instr = 8'h20;
    @(posedge clk);
    #2;
    checkOutput("f2_before_reset", 32'(dut_vec()), 32'(mk(RD | DRL | PCI, 5, 0, 1'b0)));
    #1 rst = 1'b0;
    #1 checkOutput("reset_async_quiet", 32'(dut_vec()), 32'd0);
    @(posedge clk);
    #2;
    checkOutput("reset_held_quiet", 32'(dut_vec()), 32'd0);
    rst    = 1'b1;
    chk_en = 1'b1;
    applyStimulus(4'h2, 1'b0, 0);

    $display("[TB] random instruction stream");
    for (int i = 0; i < 150; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom), $urandom_range(1, 4));
    end

    chk_en = 1'b0;
    checkOutput("model_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
